pdm_array: RTL and testbench
============================

# pdm_array

Multi-channel pulse-density modulator for the audio and LED output paths. It drives NCH independent 1-bit PDM outputs from NBITS-wide unsigned samples. Each channel advances at a programmable oversampling tick. Samples enter over a valid/ready handshake into a one-deep pending buffer, so the upstream sample FIFO sees real backpressure.

## Interface
- NBITS, 16: sample width per channel, unsigned.
- NCH, 4: channel count (1..16).
- DIV_BITS, 8: width of the tick divider.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- div  in  DIV_BITS  tick period minus one; one modulator step every div+1 clk cycles.
- ch_en  in  NCH  per-channel enable.
- din  in  NCH*NBITS  packed samples; channel c occupies bits [c*NBITS +: NBITS].
- din_valid  in  1  sample vector valid.
- din_ready  out  1  pending buffer can accept.
- dout  out  NCH  PDM bitstreams, registered.
- tick  out  1  one-cycle pulse on each modulator step.
- underrun  out  1  one-cycle pulse: a tick found the pending buffer empty.

## Operation
**Tick generator**
- Counter cnt counts 0..div.
- tick=1 when cnt==div; cnt then wraps to 0.
- div=0 gives a tick every cycle.
- A div change is compared live. If the new div is below the current cnt, the counter runs to its all-ones value and wraps.

**Buffering**
- Registers: pending[NCH*NBITS], pend_full, active[NCH*NBITS].
- din_ready = !rst && (!pend_full || tick), combinational.
- Accept: din_valid && din_ready loads pending and sets pend_full.
- On tick with pend_full: active <= pending, and pend_full clears, unless an accept happens on the same edge (then it stays set with the new data).
- On tick with !pend_full: active holds its last value, and underrun pulses in the same cycle as tick.

**Modulator** (per channel c, first order, on tick only)
- sum = {1'b0, acc[c]} + {1'b0, active_c}, NBITS+1 bits.
- dout[c] <= sum[NBITS]; acc[c] <= sum[NBITS-1:0].
- The step uses the active value from before the same-edge transfer. A newly transferred sample affects dout from the following tick.
- Density equals x/2^NBITS exactly over 2^NBITS ticks. x=0 gives constant 0; x=2^NBITS-1 gives one 0 per 2^NBITS ticks.
- ch_en[c]=0: dout[c] <= 0 and acc[c] <= 0 on every clk, tick or not. Transfers to active still occur.
- Between ticks, dout and acc hold.

**Reset**
- cnt, acc, pending, active, pend_full and dout go to 0; tick=0; underrun=0; din_ready=0 while rst is high.
- Reset mid-stream discards any pending sample. The first tick after release occurs div+1 cycles after the reset is released.

## Timing
- Accept to active: at the next tick edge. Accept to the first dout influence: one tick after that.
- dout changes only on the clk edge where tick=1.
- After an accept, din_ready drops the next cycle. It recovers in the tick cycle, combinationally.
- Throughput: at most one sample vector per tick. Zero-bubble streaming holds at div=0.

## Configuration
- PDM_ARRAY_ORDER2_EN undefined: the first-order modulator above.
- PDM_ARRAY_ORDER2_EN defined: second-order error-feedback modulator per channel. On each tick:
  - Integrators i1 and i2 are signed, NBITS+4 bits, and saturate at ±(2^(NBITS+3)-1).
  - Feedback fb = y ? 2^NBITS : 0, where y is the last dout[c].
  - i1' = i1 + x − fb; i2' = i2 + i1' − fb; dout[c] <= (i2' >= 0).
  - ch_en=0 clears i1, i2 and dout.
  - Buffering, tick and reset behaviour are unchanged.

## Test plan
- Reset release, then din=all channels 0x8000 at div=0: din_ready=1 the cycle after rst falls; after transfer, each dout toggles 1,0,1,0… (first order).
- NBITS=16, ch0=0x0000, ch1=0xFFFF, ch2=0x4000, ch3=0xC000, held for 65536 ticks: ones counts must be 0, 65535, 16384, 49152.
- div=3 with continuous din_valid: tick every 4th cycle; exactly one accept per tick after the first; underrun never asserts; dout changes only on tick edges.
- din_valid low after one sample at div=1: underrun pulses coincident with every tick after the first transfer; active holds and dout density is unchanged.
- Toggle ch_en[2] low for 10 cycles mid-stream: dout[2]=0 throughout; acc[2] is cleared; the bitstream restarts from acc=0 after re-enable. Other channels are unaffected.
- Assert rst while pend_full=1: after release, pend_full=0, dout=0, and the old pending sample never reaches active. With PDM_ARRAY_ORDER2_EN, x=0x8000 gives a ones count within ±2 of 32768 over 65536 ticks.

Source files
------------

// File: rtl/pdm_array.sv
// pdm_array: NCH-channel pulse-density modulator fed from a one-deep pending sample buffer.
// Latency: an accepted sample becomes active on the next tick and first shapes dout one tick later.
// Backpressure: din_ready drops while a sample is pending and reopens combinationally in the tick cycle.
// Optional build macro: PDM_ARRAY_ORDER2_EN selects a second-order error-feedback modulator per channel.
module pdm_array #(
    parameter int NBITS    = 16,
    parameter int NCH      = 4,
    parameter int DIV_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_BITS-1:0]   div,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH*NBITS-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [NCH-1:0]        dout,
    output logic                  tick,
    output logic                  underrun
);

    logic [DIV_BITS-1:0]  cnt;
    logic [NCH*NBITS-1:0] pending;
    logic [NCH*NBITS-1:0] active;
    logic                 pend_full;
    logic                 accept;

    // div is compared live; a div below cnt lets the counter run to all-ones and wrap
    assign tick      = !rst && (cnt == div);
    assign din_ready = !rst && (!pend_full || tick);
    assign accept    = din_valid && din_ready;
    assign underrun  = tick && !pend_full;

    // Tick divider: counts 0..div, wraps to 0 on the tick cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending buffer and active sample; a same-edge accept keeps the buffer full with new data
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            pend_full <= 1'b0;
            active    <= '0;
        end else begin
            if (accept) begin
                pending <= din;
            end
            if (accept) begin
                pend_full <= 1'b1;
            end else if (tick) begin
                pend_full <= 1'b0;
            end
            if (tick && pend_full) begin
                active <= pending;
            end
        end
    end

`ifdef PDM_ARRAY_ORDER2_EN
    localparam int IW = NBITS + 4;
    localparam int WW = NBITS + 6;
    localparam logic signed [IW-1:0] IMAX = {4'b0111, {NBITS{1'b1}}};
    localparam logic signed [IW-1:0] IMIN = {4'b1000, {(NBITS-1){1'b0}}, 1'b1};

    // Clamp a wide integrator sum back to +/-(2^(NBITS+3)-1)
    function automatic logic signed [IW-1:0] sat_i(input logic signed [WW-1:0] v);
        if (v > WW'(IMAX)) begin
            return IMAX;
        end else if (v < WW'(IMIN)) begin
            return IMIN;
        end else begin
            return v[IW-1:0];
        end
    endfunction
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [NBITS-1:0] x;
        logic             d;
        assign x       = active[c*NBITS +: NBITS];
        assign dout[c] = d;

`ifdef PDM_ARRAY_ORDER2_EN
        logic signed [IW-1:0] i1, i2, i1_n, i2_n;
        logic signed [WW-1:0] fb, s1, s2;

        // Two integrators with feedback of the previous output bit
        always_comb begin
            fb = '0;
            if (d) begin
                fb[NBITS] = 1'b1;
            end
            s1   = WW'(i1) + $signed(WW'({1'b0, x})) - fb;
            i1_n = sat_i(s1);
            s2   = WW'(i2) + WW'(i1_n) - fb;
            i2_n = sat_i(s2);
        end

        // Step on tick; a disabled channel is held cleared every cycle
        always_ff @(posedge clk) begin
            if (rst || !ch_en[c]) begin
                i1 <= '0;
                i2 <= '0;
                d  <= 1'b0;
            end else if (tick) begin
                i1 <= i1_n;
                i2 <= i2_n;
                d  <= !i2_n[IW-1];
            end
        end
`else
        logic [NBITS-1:0] acc;
        logic [NBITS:0]   sum;
        assign sum = {1'b0, acc} + {1'b0, x};

        // First-order accumulator: carry out is the PDM bit; disabled channel is held cleared
        always_ff @(posedge clk) begin
            if (rst || !ch_en[c]) begin
                acc <= '0;
                d   <= 1'b0;
            end else if (tick) begin
                acc <= sum[NBITS-1:0];
                d   <= sum[NBITS];
            end
        end
`endif
    end

endmodule

// File: tb/tb_pdm_array.sv
// tb_pdm_array: directed checks of pdm_array (default first-order build, NBITS=16, NCH=4, DIV_BITS=8).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit after that.
// Stimulus is one linear sequence of steps with hand-computed expectations.
module tb_pdm_array;

    localparam int NBITS    = 16;
    localparam int NCH      = 4;
    localparam int DIV_BITS = 8;

    logic                 clk;
    logic                 rst;
    logic [DIV_BITS-1:0]  div;
    logic [NCH-1:0]       ch_en;
    logic [NCH*NBITS-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [NCH-1:0]       dout;
    logic                 tick;
    logic                 underrun;

    int n_tests = 0;
    int n_fail  = 0;

    pdm_array #(.NBITS(NBITS), .NCH(NCH), .DIV_BITS(DIV_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .div       (div),
        .ch_en     (ch_en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .tick      (tick),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ones [NCH];
        int nrdy;
        int nund;
        int n;
        logic [NCH-1:0] prev_dout;
        logic           prev_tick;

        rst = 1'b1; div = '0; ch_en = 4'hF; din = '0; din_valid = 1'b0;
        repeat (3) cyc();
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        // Release reset, offer one 0x8000 vector at div=0
        cyc(); rst = 1'b0; din = {4{16'h8000}}; din_valid = 1'b1; #1;
        chk("c0_din_ready", 32'(din_ready), 32'd1);
        chk("c0_tick", 32'(tick), 32'd1);
        chk("c0_underrun", 32'(underrun), 32'd1);
        chk("c0_dout", 32'(dout), 32'd0);
        cyc(); din_valid = 1'b0; #1;
        chk("c1_tick", 32'(tick), 32'd1);
        chk("c1_underrun", 32'(underrun), 32'd0);
        chk("c1_din_ready", 32'(din_ready), 32'd1);
        chk("c1_dout", 32'(dout), 32'd0);
        cyc();
        chk("c2_underrun", 32'(underrun), 32'd1);
        chk("c2_dout", 32'(dout), 32'd0);
        cyc(); chk("c3_dout", 32'(dout), 32'h0);
        cyc(); chk("c4_dout", 32'(dout), 32'hF);
        cyc(); chk("c5_dout", 32'(dout), 32'h0);
        cyc(); chk("c6_dout", 32'(dout), 32'hF);

        // Channel 2 disabled for 9 cycles; others keep alternating
        ch_en = 4'b1011;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("chen_off_dout", 32'(dout), (i % 2 == 1) ? 32'hB : 32'h0);
        end
        ch_en = 4'hF;
        cyc(); chk("chen_re1_dout", 32'(dout), 32'hB);
        cyc(); chk("chen_re2_dout", 32'(dout), 32'h4);

        // Fill the pending buffer, then reset before it can transfer
        din = {4{16'hFFFF}}; din_valid = 1'b1; #1;
        chk("pend_accept_rdy", 32'(din_ready), 32'd1);
        cyc(); din_valid = 1'b0; rst = 1'b1; #1;
        chk("rst_mid_rdy", 32'(din_ready), 32'd0);
        cyc(); rst = 1'b0; #1;
        chk("post_rst_rdy", 32'(din_ready), 32'd1);
        chk("post_rst_underrun", 32'(underrun), 32'd1);
        chk("post_rst_dout", 32'(dout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_dout_hold", 32'(dout), 32'd0);
        end

        // div=3 with continuous valid: tick every 4th cycle, one accept per tick
        div = 8'd3;
        din = {16'hC000, 16'h4000, 16'hFFFF, 16'h0000};
        din_valid = 1'b1; #1;
        prev_dout = dout;
        prev_tick = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            chk("div3_tick", 32'(tick), (k % 4 == 3) ? 32'd1 : 32'd0);
            chk("div3_ready", 32'(din_ready), (k == 0 || k % 4 == 3) ? 32'd1 : 32'd0);
            chk("div3_underrun", 32'(underrun), 32'd0);
            if (k > 0 && !prev_tick) chk("div3_dout_hold", 32'(dout), 32'(prev_dout));
            prev_tick = tick;
            prev_dout = dout;
        end

        // div=0 streaming: ones density over 65536 ticks, no bubbles, no underruns
        cyc(); div = 8'd0; #1;
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        nrdy = 0;
        nund = 0;
        for (int i = 0; i < 65536; i++) begin
            for (int c = 0; c < NCH; c++) ones[c] += int'(dout[c]);
            if (!din_ready) nrdy++;
            if (underrun) nund++;
            cyc();
        end
        chk("ones_ch0", 32'(ones[0]), 32'd0);
        chk("ones_ch1", 32'(ones[1]), 32'd65535);
        chk("ones_ch2", 32'(ones[2]), 32'd16384);
        chk("ones_ch3", 32'(ones[3]), 32'd49152);
        chk("stream_not_ready", 32'(nrdy), 32'd0);
        chk("stream_underruns", 32'(nund), 32'd0);

        // Lowering div below cnt: counter runs through all-ones before the next tick
        din_valid = 1'b0; div = 8'd5; #1;
        chk("div5_tick", 32'(tick), 32'd0);
        repeat (3) cyc();
        div = 8'd1; #1;
        chk("divdrop_tick", 32'(tick), 32'd0);
        n = 0;
        while (!tick && n < 600) begin
            cyc();
            n++;
        end
        chk("divdrop_wrap_cycles", 32'(n), 32'd254);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
